interrupt_sequencer: RTL and testbench

INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

---
 rtl/interrupt_sequencer.sv | 138 +++++++++++++
 tb/tb_interrupt_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// Rotating-priority, fully nested interrupt sequencer for a two-pulse INTA bus.
// Tracks the in-service set and drives the vector on the second acknowledge.
module interrupt_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] risedBits,
  input  logic       inta,
  input  logic       eoiNonSpecific,
  input  logic       autoEoi,
  input  logic       rotateOnEoi,
  input  logic [4:0] vectorBase,
  output logic       INT,
  output logic       readPriority,
  output logic [2:0] resetIRR,
  output logic [7:0] dataBus,
  output logic       dataBusEnable,
  output logic [7:0] inService
);

  typedef enum logic [1:0] {IDLE, REQ, ACK1} state_t;

  state_t     state, state_next;
  logic [2:0] lowest_pri, lp_next;
  logic [2:0] win_q, win_next;
  logic       spur_q, spur_next;
  logic       int_next, rp_next, dbe_next;
  logic [2:0] rirr_next;
  logic [7:0] db_next, isr_next;

  logic       isr_found, req_found;
  logic [2:0] isr_top, req_top, idx;
  logic [3:0] isr_rank;

  // Walk from the highest priority downwards; requests must outrank the top ISR bit.
  always_comb begin
    isr_found = 1'b0;
    isr_top   = 3'd0;
    isr_rank  = 4'd8;
    req_found = 1'b0;
    req_top   = 3'd0;
    idx       = 3'd0;
    for (int i = 0; i < 8; i++) begin
      idx = 3'(lowest_pri + 3'(i + 1));
      if (!isr_found && inService[idx]) begin
        isr_found = 1'b1;
        isr_top   = idx;
        isr_rank  = 4'(i);
      end
    end
    for (int i = 0; i < 8; i++) begin
      idx = 3'(lowest_pri + 3'(i + 1));
      if (!req_found && 4'(i) < isr_rank && risedBits[idx]) begin
        req_found = 1'b1;
        req_top   = idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    lp_next    = lowest_pri;
    win_next   = win_q;
    spur_next  = spur_q;
    int_next   = INT;
    rp_next    = 1'b0;
    rirr_next  = resetIRR;
    db_next    = dataBus;
    dbe_next   = 1'b0;
    isr_next   = inService;
    if (eoiNonSpecific && isr_found) begin
      isr_next[isr_top] = 1'b0;
      if (rotateOnEoi) lp_next = isr_top;
    end
    unique case (state)
      IDLE: begin
        if (req_found) begin
          state_next = REQ;
          int_next   = 1'b1;
        end
      end
      REQ: begin
        if (inta) begin
          int_next   = 1'b0;
          state_next = ACK1;
          if (req_found) begin
            win_next          = req_top;
            spur_next         = 1'b0;
            isr_next[req_top] = 1'b1;
            rp_next           = 1'b1;
            rirr_next         = req_top;
          end else begin
            win_next  = 3'd7;
            spur_next = 1'b1;
          end
        end
      end
      ACK1: begin
        if (inta) begin
          db_next    = {vectorBase, win_q};
          dbe_next   = 1'b1;
          state_next = IDLE;
          if (autoEoi && !spur_q) begin
            isr_next[win_q] = 1'b0;
            if (rotateOnEoi) lp_next = win_q;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      lowest_pri    <= 3'd7;
      win_q         <= 3'd0;
      spur_q        <= 1'b0;
      INT           <= 1'b0;
      readPriority  <= 1'b0;
      resetIRR      <= 3'd0;
      dataBus       <= 8'h00;
      dataBusEnable <= 1'b0;
      inService     <= 8'h00;
    end else begin
      state         <= state_next;
      lowest_pri    <= lp_next;
      win_q         <= win_next;
      spur_q        <= spur_next;
      INT           <= int_next;
      readPriority  <= rp_next;
      resetIRR      <= rirr_next;
      dataBus       <= db_next;
      dataBusEnable <= dbe_next;
      inService     <= isr_next;
    end
  end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed scenarios plus a randomized IRR/INTA/EOI run against a
// rank-based reference model of the sequencer.
module tb_interrupt_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] risedBits = 8'h00;
  logic       inta = 1'b0;
  logic       eoiNonSpecific = 1'b0;
  logic       autoEoi = 1'b0;
  logic       rotateOnEoi = 1'b0;
  logic [4:0] vectorBase = 5'd0;
  logic       INT;
  logic       readPriority;
  logic [2:0] resetIRR;
  logic [7:0] dataBus;
  logic       dataBusEnable;
  logic [7:0] inService;

  interrupt_sequencer dut (
    .clk(clk),
    .reset_n(reset_n),
    .risedBits(risedBits),
    .inta(inta),
    .eoiNonSpecific(eoiNonSpecific),
    .autoEoi(autoEoi),
    .rotateOnEoi(rotateOnEoi),
    .vectorBase(vectorBase),
    .INT(INT),
    .readPriority(readPriority),
    .resetIRR(resetIRR),
    .dataBus(dataBus),
    .dataBusEnable(dataBusEnable),
    .inService(inService)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: phase 0 idle, 1 requesting, 2 awaiting second INTA
  int         m_phase;
  int         m_lp;
  int         m_w;
  bit         m_spur;
  logic       m_int, m_rp, m_dbe;
  logic [2:0] m_rirr;
  logic [7:0] m_db, m_isr;
  logic [7:0] irr;

  // 0 = highest priority, 7 = lowest
  function automatic int rank(int n, int lp);
    return (n - lp - 1 + 16) % 8;
  endfunction

  function automatic int top_isr(logic [7:0] isr, int lp);
    int best = -1;
    for (int n = 0; n < 8; n++)
      if (isr[n] && (best < 0 || rank(n, lp) < rank(best, lp))) best = n;
    return best;
  endfunction

  function automatic int winner(logic [7:0] req, logic [7:0] isr, int lp);
    int t = top_isr(isr, lp);
    int lim = (t < 0) ? 8 : rank(t, lp);
    int best = -1;
    for (int n = 0; n < 8; n++)
      if (req[n] && rank(n, lp) < lim &&
          (best < 0 || rank(n, lp) < rank(best, lp))) best = n;
    return best;
  endfunction

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_lp = 7; m_w = 0; m_spur = 0;
    m_int = 0; m_rp = 0; m_dbe = 0;
    m_rirr = 0; m_db = 0; m_isr = 0;
  endtask

  task automatic model_step();
    int t = top_isr(m_isr, m_lp);
    int wn = winner(risedBits, m_isr, m_lp);
    logic [7:0] nisr = m_isr;
    int nlp = m_lp;
    m_rp = 0;
    m_dbe = 0;
    if (eoiNonSpecific && t >= 0) begin
      nisr[t] = 1'b0;
      if (rotateOnEoi) nlp = t;
    end
    if (m_phase == 0) begin
      if (wn >= 0) begin m_phase = 1; m_int = 1; end
    end else if (m_phase == 1) begin
      if (inta) begin
        m_int = 0;
        m_phase = 2;
        if (wn >= 0) begin
          m_w = wn; m_spur = 0; nisr[wn] = 1'b1;
          m_rp = 1; m_rirr = 3'(wn);
        end else begin
          m_w = 7; m_spur = 1;
        end
      end
    end else begin
      if (inta) begin
        m_db = {vectorBase, 3'(m_w)};
        m_dbe = 1;
        m_phase = 0;
        if (autoEoi && !m_spur) begin
          nisr[m_w] = 1'b0;
          if (rotateOnEoi) nlp = m_w;
        end
      end
    end
    m_isr = nisr;
    m_lp = nlp;
  endtask

  task automatic compare_all();
    chk("INT", INT, m_int);
    chk("readPriority", readPriority, m_rp);
    chk("resetIRR", resetIRR, m_rirr);
    chk("dataBus", dataBus, m_db);
    chk("dataBusEnable", dataBusEnable, m_dbe);
    chk("inService", inService, m_isr);
  endtask

  task automatic tick();
    if (reset_n) model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    #2;
    compare_all();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset_n = 1'b1;

    // Basic acknowledge
    vectorBase = 5'b01000;
    risedBits = 8'h24;
    tick();
    chk("basic_int", INT, 1'b1);
    inta = 1; tick(); inta = 0;
    chk("basic_rp", readPriority, 1'b1);
    chk("basic_rirr", resetIRR, 3'd2);
    chk("basic_isr", inService, 8'h04);
    risedBits = 8'h20;
    inta = 1; tick(); inta = 0;
    chk("basic_dbe", dataBusEnable, 1'b1);
    chk("basic_db", dataBus, 8'h42);
    tick();
    chk("basic_dbe_off", dataBusEnable, 1'b0);
    chk("basic_db_hold", dataBus, 8'h42);

    // Nesting
    risedBits = 8'h08;
    tick(); tick();
    chk("nest_low_blocked", INT, 1'b0);
    risedBits = 8'h02;
    tick();
    chk("nest_int", INT, 1'b1);
    inta = 1; tick();
    chk("nest_rirr", resetIRR, 3'd1);
    chk("nest_isr", inService, 8'h06);
    risedBits = 8'h00;
    tick(); inta = 0;
    chk("nest_db", dataBus, 8'h41);
    eoiNonSpecific = 1; tick(); eoiNonSpecific = 0;
    chk("nest_eoi", inService, 8'h04);
    eoiNonSpecific = 1; tick(); eoiNonSpecific = 0;
    chk("nest_eoi2", inService, 8'h00);

    // Rotation
    rotateOnEoi = 1;
    risedBits = 8'h08;
    tick();
    inta = 1; tick();
    chk("rot_rirr3", resetIRR, 3'd3);
    risedBits = 8'h00;
    tick(); inta = 0;
    eoiNonSpecific = 1; tick(); eoiNonSpecific = 0;
    chk("rot_eoi", inService, 8'h00);
    risedBits = 8'h11;
    tick();
    chk("rot_int", INT, 1'b1);
    inta = 1; tick();
    chk("rot_ir4_wins", resetIRR, 3'd4);
    risedBits = 8'h00;
    tick(); inta = 0;
    chk("rot_db", dataBus, 8'h44);
    eoiNonSpecific = 1; tick(); eoiNonSpecific = 0;
    rotateOnEoi = 0;

    // Auto-EOI
    autoEoi = 1;
    risedBits = 8'h80;
    tick();
    inta = 1; tick();
    chk("auto_isr_set", inService, 8'h80);
    risedBits = 8'h00;
    tick(); inta = 0;
    chk("auto_isr_clr", inService, 8'h00);
    chk("auto_db", dataBus, 8'h47);
    autoEoi = 0;

    // Spurious
    vectorBase = 5'b10101;
    risedBits = 8'h01;
    tick();
    risedBits = 8'h00;
    tick();
    chk("spur_int_held", INT, 1'b1);
    inta = 1; tick();
    chk("spur_no_rp", readPriority, 1'b0);
    chk("spur_isr", inService, 8'h00);
    chk("spur_int_drop", INT, 1'b0);
    tick(); inta = 0;
    chk("spur_db", dataBus, 8'hAF);

    // Reset in ACK1
    vectorBase = 5'b01000;
    risedBits = 8'h02;
    tick();
    inta = 1; tick(); inta = 0;
    chk("rst_pre_isr", inService, 8'h02);
    #2;
    reset_n = 0;
    #1;
    model_reset();
    compare_all();
    chk("rst_isr", inService, 8'h00);
    @(posedge clk);
    #1;
    reset_n = 1;
    risedBits = 8'h00;
    inta = 1; tick(); tick(); inta = 0;
    chk("rst_no_dbe", dataBusEnable, 1'b0);
    chk("rst_no_int", INT, 1'b0);
    risedBits = 8'h02;
    tick();
    chk("rst_new_int", INT, 1'b1);
    inta = 1; tick();
    risedBits = 8'h00;
    tick(); inta = 0;
    chk("rst_new_db", dataBus, 8'h41);
    eoiNonSpecific = 1; tick(); eoiNonSpecific = 0;

    // Randomized run with an emulated IRR that drops acknowledged bits
    irr = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) begin
        autoEoi = 1'($urandom);
        rotateOnEoi = 1'($urandom);
        vectorBase = 5'($urandom);
      end
      if ($urandom_range(0, 3) == 0) irr = irr | 8'($urandom);
      risedBits = irr;
      inta = ($urandom_range(0, 2) == 0);
      eoiNonSpecific = ($urandom_range(0, 5) == 0);
      tick();
      if (m_rp) irr[m_rirr] = 1'b0;
    end
    inta = 0;
    eoiNonSpecific = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
